trig_capture_ctrl: RTL and testbench
====================================

Name: trig_capture_ctrl

Overview:
Capture controller directly downstream of the UART trigger receiver. It consumes the UARTtrig pulse and other trigger sources, runs the pre-trigger, armed and post-trigger phases of a capture, and drives write enable and address for the circular sample RAM. It reports armed, triggered and capture_done status to the command/status block.

Parameters:
DEPTH, 384, number of sample RAM entries; legal range 4 to 512.
ADDR_W, 9, address width; must satisfy 2**ADDR_W >= DEPTH.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start_cap  input  1  one-cycle pulse; starts or restarts a capture
trig_src  input  3  trigger enables: [0] UARTtrig, [1] CH_trig, [2] force (immediate)
trig_pos  input  ADDR_W  post-trigger sample count; latched at start_cap
smpl_en  input  1  one-cycle sample strobe from the decimator
UARTtrig  input  1  one-cycle match pulse from the UART trigger receiver
CH_trig  input  1  channel trigger pulse
we  output  1  RAM write enable
waddr  output  ADDR_W  RAM write address
trig_addr  output  ADDR_W  address of the first post-trigger sample
armed  output  1  high in ARMED
triggered  output  1  high from the trigger event until the next start_cap
capture_done  output  1  high in DONE

Behaviour:
- Reset values: state=IDLE, waddr=0, trig_addr=0, armed=0, triggered=0, capture_done=0, we=0, all counters 0.
- Latched at start_cap:
  - pos_r = trig_pos, clamped to DEPTH-1 when trig_pos >= DEPTH.
  - pre_target = DEPTH - pos_r, always at least 1.
- we = smpl_en & (state is PRE, ARMED or POST); combinational, no latency.
- Each write goes to the current waddr. waddr then advances by one, wrapping from DEPTH-1 to 0.
- start_cap in any state:
  - next state PRE; waddr=0, smpl_cnt=0, post_cnt=0.
  - triggered=0, capture_done=0, armed=0.
  - pos_r and pre_target latched.
  - No write occurs in the start_cap cycle, even if smpl_en is high.
- trig_evt = (trig_src[0]&UARTtrig) | (trig_src[1]&CH_trig) | trig_src[2]. It is evaluated every clock, independent of smpl_en.
- IDLE: no writes; wait for start_cap.
- PRE:
  - Each write increments smpl_cnt.
  - When the write that brings smpl_cnt to pre_target completes, next state is ARMED.
  - trig_evt is ignored in PRE.
- ARMED:
  - armed=1; writes continue circularly.
  - On trig_evt, next state is POST, triggered<=1, post_cnt<=0.
  - trig_addr <= waddr, or waddr+1 (wrapped) if a write occurs in the same cycle. A sample written in the trigger cycle counts as pre-trigger.
- POST:
  - Each write increments post_cnt.
  - When post_cnt reaches pos_r after a write, next state is DONE.
  - If pos_r==0, POST goes to DONE on the next clock with no writes.
  - Further trig_evt are ignored.
- DONE: capture_done=1, we=0, waddr frozen. Stay in DONE until start_cap.
- Outputs armed, capture_done and triggered are registered or state-decoded; waddr and trig_addr are registered.
- Asynchronous reset mid-capture returns everything to reset values immediately.

Test Plan:
- Basic UART capture (DEPTH=16, trig_pos=4, trig_src=001, smpl_en every 3rd cycle):
  - armed rises after 12 writes.
  - UARTtrig pulse between strobes gives triggered=1 and trig_addr=waddr at that cycle.
  - Exactly 4 more writes, then capture_done=1 and we stays 0.
- Same-cycle trigger and strobe: UARTtrig coincides with smpl_en while waddr=5 -> trig_addr=6; post-trigger writes go to 6,7,8,9.
- Wrap-around: DEPTH=16, trig_pos=2, trigger after 30 writes (waddr=14) -> post writes at 14 and 15, waddr wraps to 0, trig_addr=14.
- Source gating:
  - trig_src=010 with UARTtrig pulses -> no trigger; CH_trig pulse triggers.
  - Trigger pulses during PRE -> ignored, armed=0.
- Boundaries:
  - trig_pos=0 -> DONE one clock after the trigger, 0 post writes.
  - trig_pos=20 with DEPTH=16 -> clamped to 15; armed after 1 write.
- Restart/reset:
  - start_cap during POST -> waddr=0, triggered=0, state PRE.
  - rst_n low mid-ARMED -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/trig_capture_ctrl.sv
// Capture controller: sequences pre-trigger fill, armed wait and post-trigger
// capture into a circular sample RAM, and reports armed/triggered/done status.
module trig_capture_ctrl #(
    parameter int DEPTH  = 384,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_cap,
    input  logic [2:0]        trig_src,
    input  logic [ADDR_W-1:0] trig_pos,
    input  logic              smpl_en,
    input  logic              UARTtrig,
    input  logic              CH_trig,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W-1:0] trig_addr,
    output logic              armed,
    output logic              triggered,
    output logic              capture_done
);

    // Pre-trigger count can equal DEPTH (trig_pos 0), so it needs one more bit
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_ARMED = 3'd2,
        S_POST  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [ADDR_W-1:0]   r_waddr;
    logic [ADDR_W-1:0]   r_trig_addr;
    logic                r_triggered;
    logic [ADDR_W-1:0]   r_pos;
    logic [CNT_W-1:0]    r_pre_target;
    logic [CNT_W-1:0]    r_smpl_cnt;
    logic [ADDR_W-1:0]   r_post_cnt;

    logic                w_trig_evt;
    logic                w_we;
    logic                w_post_room;
    logic [ADDR_W-1:0]   w_waddr_inc;
    logic [ADDR_W-1:0]   w_pos_clamped;
    logic [CNT_W-1:0]    w_pre_target;

    assign w_trig_evt    = (trig_src[0] & UARTtrig) | (trig_src[1] & CH_trig) | trig_src[2];
    assign w_waddr_inc   = (r_waddr == LAST_ADDR) ? '0 : r_waddr + ADDR_W'(1);
    assign w_pos_clamped = ({1'b0, trig_pos} >= DEPTH_EXT) ? LAST_ADDR : trig_pos;
    assign w_pre_target  = DEPTH_CNT - CNT_W'(w_pos_clamped);

    // Only a zero-length post phase ever sits in POST with no room left
    assign w_post_room   = (r_post_cnt != r_pos);

    assign w_we = smpl_en & ~start_cap &
                  ((r_state == S_PRE) | (r_state == S_ARMED) |
                   ((r_state == S_POST) & w_post_room));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (start_cap) begin
            w_state_next = S_PRE;
        end else begin
            case (r_state)
                S_PRE: begin
                    if (w_we && (r_smpl_cnt + CNT_W'(1) == r_pre_target)) begin
                        w_state_next = S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (w_trig_evt) begin
                        w_state_next = S_POST;
                    end
                end
                S_POST: begin
                    if (!w_post_room) begin
                        w_state_next = S_DONE;
                    end else if (w_we && (r_post_cnt + ADDR_W'(1) == r_pos)) begin
                        w_state_next = S_DONE;
                    end
                end
                default: w_state_next = r_state;
            endcase
        end
    end

    always_comb begin
        we           = w_we;
        armed        = (r_state == S_ARMED);
        capture_done = (r_state == S_DONE);
    end

    assign waddr     = r_waddr;
    assign trig_addr = r_trig_addr;
    assign triggered = r_triggered;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_waddr      <= '0;
            r_trig_addr  <= '0;
            r_triggered  <= 1'b0;
            r_pos        <= '0;
            r_pre_target <= '0;
            r_smpl_cnt   <= '0;
            r_post_cnt   <= '0;
        end else if (start_cap) begin
            r_waddr      <= '0;
            r_triggered  <= 1'b0;
            r_pos        <= w_pos_clamped;
            r_pre_target <= w_pre_target;
            r_smpl_cnt   <= '0;
            r_post_cnt   <= '0;
        end else begin
            if (w_we) begin
                r_waddr <= w_waddr_inc;
            end
            if ((r_state == S_PRE) && w_we) begin
                r_smpl_cnt <= r_smpl_cnt + CNT_W'(1);
            end
            // A sample written in the trigger cycle belongs to the pre-trigger window
            if ((r_state == S_ARMED) && w_trig_evt) begin
                r_triggered <= 1'b1;
                r_post_cnt  <= '0;
                r_trig_addr <= w_we ? w_waddr_inc : r_waddr;
            end
            if ((r_state == S_POST) && w_we) begin
                r_post_cnt <= r_post_cnt + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_trig_capture_ctrl.sv
// Bench for trig_capture_ctrl: constant vector table, directed capture
// scenarios and random traffic, all checked against a count-based model.
module tb_trig_capture_ctrl;

    localparam int D  = 16;
    localparam int AW = 5;

    logic          clk;
    logic          rst_n;
    logic          start_cap;
    logic [2:0]    trig_src;
    logic [AW-1:0] trig_pos;
    logic          smpl_en;
    logic          UARTtrig;
    logic          CH_trig;
    logic          we;
    logic [AW-1:0] waddr;
    logic [AW-1:0] trig_addr;
    logic          armed;
    logic          triggered;
    logic          capture_done;

    trig_capture_ctrl #(.DEPTH(D), .ADDR_W(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_cap    (start_cap),
        .trig_src     (trig_src),
        .trig_pos     (trig_pos),
        .smpl_en      (smpl_en),
        .UARTtrig     (UARTtrig),
        .CH_trig      (CH_trig),
        .we           (we),
        .waddr        (waddr),
        .trig_addr    (trig_addr),
        .armed        (armed),
        .triggered    (triggered),
        .capture_done (capture_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: capture described by write counts rather than states
    bit m_started, m_trig, m_done;
    int m_mw, m_pt, m_pos, m_pw, m_taddr;

    logic          s_we;
    logic [AW-1:0] s_waddr;
    int            wq[$];

    typedef struct {
        logic          sc;
        logic [2:0]    src;
        logic [AW-1:0] tp;
        logic          se, ut, ct;
        logic          e_we;
        logic [AW-1:0] e_waddr;
        logic          e_armed, e_trg, e_done;
        logic [AW-1:0] e_taddr;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_started = 0; m_trig = 0; m_done = 0;
        m_mw = 0; m_pt = 0; m_pos = 0; m_pw = 0; m_taddr = 0;
    endtask

    // Called at posedge+1; applies one cycle of inputs and checks against the model
    task automatic step(input logic sc, input logic [2:0] src, input logic [AW-1:0] tp,
                        input logic se, input logic ut, input logic ct);
        logic e_we, evt;
        int p, w;
        start_cap = sc; trig_src = src; trig_pos = tp;
        smpl_en = se; UARTtrig = ut; CH_trig = ct;
        evt  = (src[0] & ut) | (src[1] & ct) | src[2];
        e_we = se && !sc && m_started && !m_done && !(m_trig && m_pw == m_pos);
        #3;
        s_we = we; s_waddr = waddr;
        chk("we", we, e_we);
        if (we === 1'b1) wq.push_back(int'(waddr));
        @(posedge clk); #1;
        if (sc) begin
            p = (int'(tp) >= D) ? D - 1 : int'(tp);
            m_started = 1; m_pos = p; m_pt = D - p;
            m_mw = 0; m_trig = 0; m_pw = 0; m_done = 0;
        end else if (m_started) begin
            w = e_we ? 1 : 0;
            if (!m_trig && m_mw >= m_pt && evt) begin
                m_trig = 1; m_taddr = (m_mw + w) % D; m_pw = 0;
            end else if (m_trig && !m_done) begin
                if (m_pw + w == m_pos) m_done = 1;
                m_pw += w;
            end
            m_mw += w;
        end
        chk("waddr", waddr, m_mw % D);
        chk("armed", armed, m_started && !m_trig && m_mw >= m_pt);
        chk("triggered", triggered, m_trig);
        chk("capture_done", capture_done, m_done);
        chk("trig_addr", trig_addr, m_taddr);
        start_cap = 0; UARTtrig = 0; CH_trig = 0;
    endtask

    initial begin
        int wr, k;
        tbl[0] = '{1'b1, 3'b100, 5'd20, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0};
        tbl[1] = '{1'b0, 3'b100, 5'd0,  1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 5'd0};
        tbl[2] = '{1'b0, 3'b100, 5'd0,  1'b1, 1'b0, 1'b0, 1'b1, 5'd2, 1'b0, 1'b1, 1'b0, 5'd2};
        tbl[3] = '{1'b0, 3'b000, 5'd0,  1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 5'd2};
        tbl[4] = '{1'b0, 3'b000, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0, 5'd2};
        tbl[5] = '{1'b1, 3'b001, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd2};
        tbl[6] = '{1'b0, 3'b001, 5'd0,  1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 5'd2};

        rst_n = 0; start_cap = 0; trig_src = 0; trig_pos = 0;
        smpl_en = 0; UARTtrig = 0; CH_trig = 0;
        model_reset();
        #12;
        chk("rst_we", we, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_taddr", trig_addr, 0);
        chk("rst_armed", armed, 0);
        chk("rst_trig", triggered, 0);
        chk("rst_done", capture_done, 0);
        rst_n = 1;
        @(posedge clk); #1;

        // Clamped trig_pos, force trigger, restart during POST
        foreach (tbl[i]) begin
            step(tbl[i].sc, tbl[i].src, tbl[i].tp, tbl[i].se, tbl[i].ut, tbl[i].ct);
            $display("[TB] vec %0d we=%0d waddr=%0d armed=%0d trig=%0d done=%0d taddr=%0d",
                     i, s_we, waddr, armed, triggered, capture_done, trig_addr);
            chk("tbl_we", s_we, tbl[i].e_we);
            chk("tbl_waddr", waddr, tbl[i].e_waddr);
            chk("tbl_armed", armed, tbl[i].e_armed);
            chk("tbl_trig", triggered, tbl[i].e_trg);
            chk("tbl_done", capture_done, tbl[i].e_done);
            chk("tbl_taddr", trig_addr, tbl[i].e_taddr);
        end

        // Basic UART capture, strobe every third cycle
        step(1'b1, 3'b001, 5'd4, 1'b0, 1'b0, 1'b0);
        wr = 0; k = 0;
        while (armed !== 1'b1 && k < 200) begin
            step(1'b0, 3'b001, 5'd0, (k % 3 == 2), 1'b0, 1'b0);
            if (s_we === 1'b1) wr++;
            k++;
        end
        chk("A_writes_to_arm", wr, 12);
        step(1'b0, 3'b001, 5'd0, 1'b0, 1'b1, 1'b0);
        chk("A_triggered", triggered, 1);
        chk("A_trig_addr", trig_addr, 12);
        wr = 0; k = 0;
        while (capture_done !== 1'b1 && k < 200) begin
            step(1'b0, 3'b001, 5'd0, (k % 3 == 2), 1'b0, 1'b0);
            if (s_we === 1'b1) wr++;
            k++;
        end
        chk("A_post_writes", wr, 4);
        step(1'b0, 3'b001, 5'd0, 1'b1, 1'b0, 1'b0);
        chk("A_done_no_we", s_we, 0);
        $display("[TB] basic uart capture: post writes=%0d trig_addr=%0d", wr, trig_addr);

        // Trigger coincident with a strobe at waddr 5
        step(1'b1, 3'b001, 5'd4, 1'b0, 1'b0, 1'b0);
        k = 0;
        while (!(armed === 1'b1 && waddr == 5) && k < 100) begin
            step(1'b0, 3'b001, 5'd0, 1'b1, 1'b0, 1'b0);
            k++;
        end
        chk("B_waddr", waddr, 5);
        step(1'b0, 3'b001, 5'd0, 1'b1, 1'b1, 1'b0);
        chk("B_trig_addr", trig_addr, 6);
        wq.delete();
        k = 0;
        while (capture_done !== 1'b1 && k < 100) begin
            step(1'b0, 3'b001, 5'd0, 1'b1, 1'b0, 1'b0);
            k++;
        end
        chk("B_post_count", wq.size(), 4);
        for (int i = 0; i < wq.size() && i < 4; i++) chk("B_post_addr", wq[i], 6 + i);
        $display("[TB] same-cycle trigger: trig_addr=%0d post writes=%0d", trig_addr, wq.size());

        // Wrap-around: trigger after 30 writes
        step(1'b1, 3'b001, 5'd2, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) step(1'b0, 3'b001, 5'd0, 1'b1, 1'b0, 1'b0);
        chk("C_waddr", waddr, 14);
        chk("C_armed", armed, 1);
        step(1'b0, 3'b001, 5'd0, 1'b0, 1'b1, 1'b0);
        chk("C_trig_addr", trig_addr, 14);
        wq.delete();
        k = 0;
        while (capture_done !== 1'b1 && k < 100) begin
            step(1'b0, 3'b001, 5'd0, 1'b1, 1'b0, 1'b0);
            k++;
        end
        chk("C_post_count", wq.size(), 2);
        for (int i = 0; i < wq.size() && i < 2; i++) chk("C_post_addr", wq[i], 14 + i);
        chk("C_wrapped", waddr, 0);
        $display("[TB] wrap capture: trig_addr=%0d waddr=%0d", trig_addr, waddr);

        // Source gating and triggers during PRE
        step(1'b1, 3'b010, 5'd4, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 3'b010, 5'd0, 1'b1, 1'b1, i[0]);
        chk("D_pre_armed", armed, 0);
        chk("D_pre_trig", triggered, 0);
        for (int i = 0; i < 6; i++) step(1'b0, 3'b010, 5'd0, 1'b1, 1'b1, i[0]);
        chk("D_armed", armed, 1);
        for (int i = 0; i < 3; i++) step(1'b0, 3'b010, 5'd0, 1'b0, 1'b1, 1'b0);
        chk("D_uart_gated", triggered, 0);
        step(1'b0, 3'b010, 5'd0, 1'b0, 1'b0, 1'b1);
        chk("D_ch_trig", triggered, 1);
        $display("[TB] source gating: triggered=%0d trig_addr=%0d", triggered, trig_addr);

        // trig_pos 0: DONE one clock after the trigger, no post writes
        step(1'b1, 3'b100, 5'd0, 1'b0, 1'b0, 1'b0);
        k = 0;
        while (armed !== 1'b1 && k < 100) begin
            step(1'b0, 3'b100, 5'd0, 1'b1, 1'b0, 1'b0);
            k++;
        end
        step(1'b0, 3'b100, 5'd0, 1'b1, 1'b0, 1'b0);
        chk("E_triggered", triggered, 1);
        chk("E_not_done", capture_done, 0);
        step(1'b0, 3'b100, 5'd0, 1'b1, 1'b0, 1'b0);
        chk("E_no_post_we", s_we, 0);
        chk("E_done", capture_done, 1);
        $display("[TB] zero post capture: done=%0d trig_addr=%0d", capture_done, trig_addr);

        // Asynchronous reset while armed
        step(1'b1, 3'b001, 5'd4, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 13; i++) step(1'b0, 3'b001, 5'd0, 1'b1, 1'b0, 1'b0);
        chk("H_armed", armed, 1);
        #1;
        smpl_en = 1; rst_n = 0;
        #1;
        chk("H_we", we, 0);
        chk("H_waddr", waddr, 0);
        chk("H_taddr", trig_addr, 0);
        chk("H_armed0", armed, 0);
        chk("H_trig", triggered, 0);
        chk("H_done", capture_done, 0);
        $display("[TB] async reset: we=%0d waddr=%0d armed=%0d", we, waddr, armed);
        model_reset();
        smpl_en = 0;
        #2 rst_n = 1;
        @(posedge clk); #1;

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            step((i == 0) || ($urandom_range(39) == 0),
                 3'($urandom_range(7)), 5'($urandom_range(31)),
                 1'($urandom_range(1)), $urandom_range(4) == 0, $urandom_range(4) == 0);
        end
        $display("[TB] random: 1500 cycles, waddr=%0d done=%0d", waddr, capture_done);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
